// File: rtl/data_mem_hs_if.sv
// Request/response bundle between the MEM stage (master) and the data RAM (slave).
// Handshake: a beat transfers on a rising edge where valid and ready are both high;
// the sender holds its payload stable while valid is high and ready is low.
interface data_mem_hs_if #(
   parameter int ADDR_WIDTH = 32
) ();
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic [2:0]            req_load_type;
   logic [1:0]            req_store_type;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [31:0]           resp_rdata;
   logic                  resp_err;
   logic [1:0]            resp_err_code;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_load_type, req_store_type,
      output resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err, resp_err_code
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_load_type, req_store_type,
      input  resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err, resp_err_code
   );
endinterface

// File: rtl/data_mem_hs.sv
// Word-organised byte-addressable data RAM with RV32 load extension, store lane
// steering, error flagging and a configurable number of wait states.
module data_mem_hs #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   data_mem_hs_if.slave  bus,
   output logic [1:0]    dbg_state_o
);
   localparam int                    IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
   localparam logic [3:0]            WAIT_CNT   = 4'(WAIT_STATES);
   localparam bit                    NO_WAIT    = (WAIT_STATES == 0);

   localparam logic [2:0] LT_LB = 3'b000, LT_LH = 3'b001, LT_LW = 3'b010,
                          LT_LBU = 3'b011, LT_LHU = 3'b100;
   localparam logic [1:0] ST_SB = 2'b00, ST_SH = 2'b01, ST_SW = 2'b10;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [2:0]            ltype_q, ltype_d;
   logic [1:0]            stype_q, stype_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [1:0]            code_q, code_d;

   logic [31:0]           mem_q [DEPTH_WORDS];

   logic                  do_access;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic                  acc_write;
   logic [2:0]            acc_lt;
   logic [1:0]            acc_st;
   logic [31:0]           acc_wdata;
   logic                  acc_illegal, acc_half, acc_word, acc_misal, acc_oor;
   logic [1:0]            acc_code;
   logic [IDX_W-1:0]      acc_idx;
   logic [31:0]           rd_word, ld_data, st_data;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [3:0]            st_be;

   // In IDLE the access (zero-wait case) must use the request on the bus, since
   // the latch and the access happen on the same edge.
   always_comb begin
      acc_addr  = (state_q == S_IDLE) ? bus.req_addr       : addr_q;
      acc_write = (state_q == S_IDLE) ? bus.req_write      : write_q;
      acc_lt    = (state_q == S_IDLE) ? bus.req_load_type  : ltype_q;
      acc_st    = (state_q == S_IDLE) ? bus.req_store_type : stype_q;
      acc_wdata = (state_q == S_IDLE) ? bus.req_wdata      : wdata_q;
   end

   always_comb begin
      acc_illegal = acc_write ? (acc_st == 2'b11) : (acc_lt > LT_LHU);
      acc_half    = acc_write ? (acc_st == ST_SH) : (acc_lt == LT_LH || acc_lt == LT_LHU);
      acc_word    = acc_write ? (acc_st == ST_SW) : (acc_lt == LT_LW);
      acc_misal   = (acc_half && acc_addr[0]) || (acc_word && (acc_addr[1:0] != 2'b00));
      acc_oor     = ({1'b0, acc_addr} >= ADDR_LIMIT);
      if (acc_illegal)    acc_code = 2'b11;
      else if (acc_misal) acc_code = 2'b01;
      else if (acc_oor)   acc_code = 2'b10;
      else                acc_code = 2'b00;
   end

   always_comb begin
      acc_idx = acc_addr[IDX_W+1:2];
      rd_word = mem_q[acc_idx];
      case (acc_addr[1:0])
         2'b00:   ld_byte = rd_word[7:0];
         2'b01:   ld_byte = rd_word[15:8];
         2'b10:   ld_byte = rd_word[23:16];
         default: ld_byte = rd_word[31:24];
      endcase
      ld_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (acc_lt)
         LT_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         LT_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         LT_LW:   ld_data = rd_word;
         LT_LBU:  ld_data = {24'd0, ld_byte};
         LT_LHU:  ld_data = {16'd0, ld_half};
         default: ld_data = 32'd0;
      endcase
   end

   always_comb begin
      st_be   = 4'b0000;
      st_data = acc_wdata;
      case (acc_st)
         ST_SB: begin
            st_be   = 4'b0001 << acc_addr[1:0];
            st_data = {4{acc_wdata[7:0]}};
         end
         ST_SH: begin
            st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
            st_data = {2{acc_wdata[15:0]}};
         end
         ST_SW:   st_be = 4'b1111;
         default: st_be = 4'b0000;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      ltype_d   = ltype_q;
      stype_d   = stype_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      code_d    = code_q;
      do_access = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               write_d = bus.req_write;
               ltype_d = bus.req_load_type;
               stype_d = bus.req_store_type;
               wdata_d = bus.req_wdata;
               if (NO_WAIT) begin
                  do_access = 1'b1;
                  state_d   = S_RESP;
               end else begin
                  cnt_d   = WAIT_CNT;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               do_access = 1'b1;
               state_d   = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               state_d = S_IDLE;
               rdata_d = 32'd0;
               err_d   = 1'b0;
               code_d  = 2'b00;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (do_access) begin
         err_d   = (acc_code != 2'b00);
         code_d  = acc_code;
         rdata_d = (acc_write || acc_code != 2'b00) ? 32'd0 : ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         ltype_q <= 3'd0;
         stype_q <= 2'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         code_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         ltype_q <= ltype_d;
         stype_q <= stype_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   // RAM contents survive reset; a reset edge cancels a pending store.
   always_ff @(posedge clk) begin
      if (rst_n && do_access && acc_write && (acc_code == 2'b00)) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) mem_q[acc_idx][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

   assign bus.req_ready     = (state_q == S_IDLE);
   assign bus.resp_valid    = (state_q == S_RESP);
   assign bus.resp_rdata    = rdata_q;
   assign bus.resp_err      = err_q;
   assign bus.resp_err_code = code_q;
   assign dbg_state_o       = state_q;
endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
Parametrised successor to the single-cycle data memory. It is a byte-addressable, word-organised data RAM with a valid/ready request and response handshake and a configurable number of wait states. It performs RV32 load sign/zero extension and store byte-lane steering internally, and flags misaligned, out-of-range and illegal-type accesses. It sits between the MEM stage and the data RAM; the pipeline stalls on req_ready/resp_valid.

Parameters:
ADDR_WIDTH, 32, width of the byte address.
DEPTH_WORDS, 256, number of 32-bit words; a power of two, at least 4.
WAIT_STATES, 0, extra cycles inserted between request accept and memory access; range 0..15.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
req_write  input  1  1 = store, 0 = load.
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  32  store data; right-aligned in the low bits.
req_load_type  input  3  000=LB, 001=LH, 010=LW, 011=LBU, 100=LHU.
req_store_type  input  2  00=SB, 01=SH, 10=SW.
resp_valid  output  1  response present.
resp_ready  input  1  consumer takes the response.
resp_rdata  output  32  extended load data; 0 for stores and for errors.
resp_err  output  1  access rejected.
resp_err_code  output  2  00=none, 01=misaligned, 10=out of range, 11=illegal type.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, wait counter=0, req_ready=1 on the following cycle, resp_valid=0, resp_rdata=0, resp_err=0, resp_err_code=00. RAM contents are not reset.
- FSM has three states: IDLE, WAIT, RESP. req_ready = (state==IDLE); it is a registered-state decode with no combinational path from req_valid.
- IDLE: a request is accepted when req_valid=1. On that edge, latch addr, write, types and wdata. If WAIT_STATES=0, do the access and go to RESP. Otherwise load the counter with WAIT_STATES and go to WAIT.
- WAIT: decrement the counter each cycle. On the edge where the counter equals 1, do the access and go to RESP.
- Latency: resp_valid rises exactly WAIT_STATES+1 cycles after the accept edge.
- RESP: hold resp_* stable while resp_ready=0. When resp_ready=1, go to IDLE and drop resp_valid next cycle. Minimum spacing between accepts is WAIT_STATES+2 cycles, with one access outstanding.
- Error check runs on the latched request. Priority is illegal type > misaligned > out of range.
  - Illegal: load type 101..111, or store type 11.
  - Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]!=00.
  - Out of range: addr >= 4*DEPTH_WORDS, compared on the full ADDR_WIDTH with no wrap-around.
  - An erroring store does not write memory. An erroring access returns rdata=0 and err=1.
- Store: word index is addr[log2(DEPTH_WORDS)+1:2].
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes are unchanged. resp_rdata=0.
- Load: select the byte or halfword by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- A load issued after a store's response returns the updated data; no hazard exists because only one access is outstanding.
- Reset mid-operation: if rst_n is low in WAIT, the pending store is dropped and memory is untouched. If rst_n is low in RESP, the response is discarded.
- req_* inputs are ignored outside IDLE.

Test Plan:
- WAIT_STATES=0: SW 0xDEADBEEF to 0x10, then LW 0x10 -> resp_rdata=0xDEADBEEF, err=0, resp_valid exactly 1 cycle after each accept.
- SB 0x80 to 0x21, then LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; LW 0x20 -> byte 1 =0x80, other bytes unchanged from prior contents.
- LW 0x22 -> err=1, code=01, rdata=0. SH 0x13 -> code=01 and memory at 0x10 unchanged. Load type 111 -> code=11.
- DEPTH_WORDS=256: LW 0x400 -> code=10; SW 0x3FC succeeds and reads back.
- WAIT_STATES=3, resp_ready held low for 5 cycles: resp_valid rises 4 cycles after accept, rdata stable throughout, req_ready=0 until the cycle after the resp_ready handshake.
- WAIT_STATES=3: SW 0x12345678 to 0x0, rst_n low during WAIT, then LW 0x0 -> returns prior contents. Outputs are 0 and req_ready=1 the cycle after reset releases.
